// File: rtl/urv_dm_wb_bridge_pkg.sv
// Shared definitions for the uRV data-memory to Wishbone bridge:
// FSM state encodings, the error-load default and timeout counter sizing.
package urv_dm_wb_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } bridge_state_t;

  localparam logic [31:0] c_default_error_load = 32'hDEAD_BEEF;
  localparam int          c_min_timeout_width  = 8;

  // The timeout counter never shrinks below 8 bits, even for small timeouts.
  function automatic int timeout_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w > c_min_timeout_width) ? w : c_min_timeout_width;
  endfunction

endpackage

// File: rtl/urv_dm_wb_bridge_if.sv
// Wishbone B4 pipelined single-beat bus between the bridge (master) and the
// interconnect/slave.
interface urv_dm_wb_bridge_if;

  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_stall_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i
  );

endinterface

// File: rtl/urv_dm_wb_bridge.sv
// Turns uRV dm_* load/store strobes into single-beat pipelined Wishbone cycles,
// one in flight at a time, with bus-error and timeout reporting.
module urv_dm_wb_bridge
  import urv_dm_wb_bridge_pkg::*;
#(
  parameter int          g_timeout_cycles   = 255,
  parameter logic [31:0] g_error_load_value = c_default_error_load
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [31:0]                dm_addr_i,
  input  logic [31:0]                dm_data_s_i,
  input  logic [3:0]                 dm_data_select_i,
  input  logic                       dm_load_i,
  input  logic                       dm_store_i,
  output logic                       dm_ready_o,
  output logic [31:0]                dm_data_l_o,
  output logic                       dm_load_done_o,
  output logic                       dm_store_done_o,
  output logic                       bus_error_o,
  urv_dm_wb_bridge_if.master         wb
);

  localparam int                  c_cnt_w    = timeout_width(g_timeout_cycles);
  localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(g_timeout_cycles - 1);
  localparam bit                  c_to_en    = (g_timeout_cycles != 0);

  bridge_state_t      state;
  logic [c_cnt_w-1:0] cnt;
  logic               timeout_hit;
  logic               bus_done;
  logic               bus_fail;

  assign timeout_hit = c_to_en && (cnt == c_cnt_last);

  // An ack/err only counts once the strobe has been taken; ack+err together is
  // an error, and an ack in the final timeout cycle still wins over the timeout.
  always_comb begin
    bus_done = 1'b0;
    bus_fail = 1'b0;
    case (state)
      ST_ISSUE: begin
        bus_done = !wb.wb_stall_i && (wb.wb_ack_i || wb.wb_err_i);
        bus_fail = !wb.wb_stall_i && wb.wb_err_i;
      end
      ST_WAIT: begin
        bus_done = wb.wb_ack_i || wb.wb_err_i || timeout_hit;
        bus_fail = wb.wb_err_i || (timeout_hit && !wb.wb_ack_i);
      end
      default: begin
        bus_done = 1'b0;
        bus_fail = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      dm_ready_o      <= 1'b1;
      dm_data_l_o     <= '0;
      dm_load_done_o  <= 1'b0;
      dm_store_done_o <= 1'b0;
      bus_error_o     <= 1'b0;
      wb.wb_cyc_o     <= 1'b0;
      wb.wb_stb_o     <= 1'b0;
      wb.wb_we_o      <= 1'b0;
      wb.wb_sel_o     <= '0;
      wb.wb_adr_o     <= '0;
      wb.wb_dat_o     <= '0;
    end else begin
      dm_load_done_o  <= 1'b0;
      dm_store_done_o <= 1'b0;
      bus_error_o     <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (dm_load_i || dm_store_i) begin
            state       <= ST_ISSUE;
            cnt         <= '0;
            dm_ready_o  <= 1'b0;
            wb.wb_cyc_o <= 1'b1;
            wb.wb_stb_o <= 1'b1;
            wb.wb_we_o  <= dm_store_i;
            wb.wb_sel_o <= dm_data_select_i;
            wb.wb_adr_o <= dm_addr_i & 32'hFFFF_FFFC;
            wb.wb_dat_o <= dm_data_s_i;
          end
        end

        ST_ISSUE: begin
          if (!wb.wb_stall_i) begin
            wb.wb_stb_o <= 1'b0;
            if (!bus_done) begin
              state <= ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          if (!bus_done) begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase

      if (bus_done) begin
        state           <= ST_IDLE;
        dm_ready_o      <= 1'b1;
        wb.wb_cyc_o     <= 1'b0;
        wb.wb_stb_o     <= 1'b0;
        bus_error_o     <= bus_fail;
        dm_store_done_o <= wb.wb_we_o;
        dm_load_done_o  <= !wb.wb_we_o;
        if (!wb.wb_we_o) begin
          dm_data_l_o <= bus_fail ? g_error_load_value : wb.wb_dat_i;
        end
      end
    end
  end

endmodule
